// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Exports: arb_state_t (FSM states), grant_t (arbitration winner), STARVE_W.
// No logic; imported by mem_port_arbiter and arb_starve_cnt.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Width of the fetch starvation counter; holds MAX_WAIT values 1..15.
  localparam int STARVE_W = 4;

endpackage

// File: rtl/arb_starve_cnt.sv
// Saturating count of data grants made while a fetch waits; raises the fetch-force flag.
// Ports: clk/rst (sync, active-high); idle_i, ireq_i, data_gnt_i, fetch_gnt_i in;
//        force_fetch_o out (fetch must win this IDLE cycle).
module arb_starve_cnt #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic idle_i,
  input  logic ireq_i,
  input  logic data_gnt_i,
  input  logic fetch_gnt_i,
  output logic force_fetch_o
);
  import mem_arb_pkg::*;

  localparam logic [STARVE_W-1:0] MAX_CNT = STARVE_W'(MAX_WAIT);

  logic [STARVE_W-1:0] cnt_q, cnt_d;

  // Grants are only made in IDLE, so a data grant with no fetch pending
  // falls through to the idle-without-fetch clear.
  always_comb begin
    cnt_d = cnt_q;
    if (fetch_gnt_i) begin
      cnt_d = '0;
    end else if (data_gnt_i && ireq_i) begin
      if (cnt_q != MAX_CNT) cnt_d = cnt_q + 1'b1;
    end else if (idle_i && !ireq_i) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign force_fetch_o = ireq_i && (cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and data requesters onto one single-ported memory with a
// request/ready handshake; returns read data with a one-cycle valid pulse.
// Ports: fetch (IReqF/IAddrF -> IRdataF/IValidF), data (DReqM/DWeM/DAddrM/DWdataM
//        -> DRdataM/DValidM), stalls (StallFMem/StallMMem), memory (MemReq/MemWe/
//        MemAddr/MemWdata <- MemRdata/MemReady). Optional MEM_ARB_PERF_EN adds
//        FetchGrantCnt, DataGrantCnt and ContendCnt.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              IReqF,
  input  logic [ADDR_W-1:0] IAddrF,
  output logic [DATA_W-1:0] IRdataF,
  output logic              IValidF,
  input  logic              DReqM,
  input  logic              DWeM,
  input  logic [ADDR_W-1:0] DAddrM,
  input  logic [DATA_W-1:0] DWdataM,
  output logic [DATA_W-1:0] DRdataM,
  output logic              DValidM,
  output logic              StallFMem,
  output logic              StallMMem,
  output logic              MemReq,
  output logic              MemWe,
  output logic [ADDR_W-1:0] MemAddr,
  output logic [DATA_W-1:0] MemWdata,
  input  logic [DATA_W-1:0] MemRdata,
  input  logic              MemReady
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]       FetchGrantCnt,
  output logic [31:0]       DataGrantCnt,
  output logic [31:0]       ContendCnt
`endif
);
  import mem_arb_pkg::*;

  arb_state_t        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              ivalid_q, ivalid_d;
  logic              dvalid_q, dvalid_d;
  logic [DATA_W-1:0] irdata_q, irdata_d;
  logic [DATA_W-1:0] drdata_q, drdata_d;

  logic   force_fetch;
  logic   fetch_gnt, data_gnt;
  logic   any_req;
  grant_t win;

  // Data wins by default; fetch wins when alone or when it has been starved.
  assign any_req = IReqF || DReqM;
  assign win     = (IReqF && (force_fetch || !DReqM)) ? GNT_I : GNT_D;

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ivalid_d    = 1'b0;
    dvalid_d    = 1'b0;
    irdata_d    = irdata_q;
    drdata_d    = drdata_q;
    fetch_gnt   = 1'b0;
    data_gnt    = 1'b0;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_req_d = 1'b1;
          if (win == GNT_I) begin
            fetch_gnt  = 1'b1;
            state_d    = BUSY_I;
            mem_we_d   = 1'b0;
            mem_addr_d = IAddrF;
          end else begin
            data_gnt    = 1'b1;
            state_d     = BUSY_D;
            mem_we_d    = DWeM;
            mem_addr_d  = DAddrM;
            mem_wdata_d = DWdataM;
          end
        end
      end
      BUSY_I, BUSY_D: begin
        // Valid is registered on completion so it is high throughout RESP.
        if (MemReady) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = RESP;
          if (state_q == BUSY_I) begin
            ivalid_d = 1'b1;
            irdata_d = MemRdata;
          end else begin
            dvalid_d = 1'b1;
            drdata_d = mem_we_q ? '0 : MemRdata;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      ivalid_q    <= 1'b0;
      dvalid_q    <= 1'b0;
      irdata_q    <= '0;
      drdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      ivalid_q    <= ivalid_d;
      dvalid_q    <= dvalid_d;
      irdata_q    <= irdata_d;
      drdata_q    <= drdata_d;
    end
  end

  arb_starve_cnt #(
    .MAX_WAIT(MAX_WAIT)
  ) u_starve (
    .clk          (clk),
    .rst          (rst),
    .idle_i       (state_q == IDLE),
    .ireq_i       (IReqF),
    .data_gnt_i   (data_gnt),
    .fetch_gnt_i  (fetch_gnt),
    .force_fetch_o(force_fetch)
  );

  assign MemReq    = mem_req_q;
  assign MemWe     = mem_we_q;
  assign MemAddr   = mem_addr_q;
  assign MemWdata  = mem_wdata_q;
  assign IValidF   = ivalid_q;
  assign DValidM   = dvalid_q;
  assign IRdataF   = irdata_q;
  assign DRdataM   = drdata_q;
  assign StallFMem = IReqF && !ivalid_q;
  assign StallMMem = DReqM && !dvalid_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] fetch_cnt_q, data_cnt_q, contend_cnt_q;
  logic        contend;

  assign contend = (state_q == IDLE) && IReqF && DReqM;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q   <= '0;
      data_cnt_q    <= '0;
      contend_cnt_q <= '0;
    end else begin
      if (fetch_gnt && (fetch_cnt_q != '1))  fetch_cnt_q   <= fetch_cnt_q + 1'b1;
      if (data_gnt && (data_cnt_q != '1))    data_cnt_q    <= data_cnt_q + 1'b1;
      if (contend && (contend_cnt_q != '1))  contend_cnt_q <= contend_cnt_q + 1'b1;
    end
  end

  assign FetchGrantCnt = fetch_cnt_q;
  assign DataGrantCnt  = data_cnt_q;
  assign ContendCnt    = contend_cnt_q;
`endif

endmodule
